// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: ID instruction and kill controls in, per-stage control bundle out.
// The master side drives the instruction stream; the slave side is the control unit.
interface pipelined_control_unit_if #(
    parameter int ALUOP_W = 4,
    parameter int REG_W   = 5
);
    logic [31:0]        Instruction;
    logic               InstrValid;
    logic               Flush;
    logic               Stall;
    logic               Jump;
    logic               JRMux;
    logic               JalMux;
    logic               IllegalInstr;
    logic [ALUOP_W-1:0] EX_ALUOp;
    logic               EX_ALUSrc;
    logic [2:0]         EX_BrType;
    logic               MEM_MemRead;
    logic               MEM_MemWrite;
    logic [1:0]         MEM_Size;
    logic               WB_RegWrite;
    logic               WB_MemToReg;
    logic [REG_W-1:0]   WB_WriteReg;

    modport master (
        output Instruction, InstrValid, Flush,
        input  Stall, Jump, JRMux, JalMux, IllegalInstr,
        input  EX_ALUOp, EX_ALUSrc, EX_BrType,
        input  MEM_MemRead, MEM_MemWrite, MEM_Size,
        input  WB_RegWrite, WB_MemToReg, WB_WriteReg
    );

    modport slave (
        input  Instruction, InstrValid, Flush,
        output Stall, Jump, JRMux, JalMux, IllegalInstr,
        output EX_ALUOp, EX_ALUSrc, EX_BrType,
        output MEM_MemRead, MEM_MemWrite, MEM_Size,
        output WB_RegWrite, WB_MemToReg, WB_WriteReg
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Five-stage MIPS control unit: decodes the ID instruction, pipes the control
// bundle through ID/EX, EX/MEM and MEM/WB, and raises a one-cycle load-use stall.
module pipelined_control_unit #(
    parameter int ALUOP_W   = 4,
    parameter int REG_W     = 5,
    parameter bit HAZARD_EN = 1'b1
) (
    input logic                    Clk,
    input logic                    Reset,
    pipelined_control_unit_if.slave bus
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'd2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'd3);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4'd4);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4'd5);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'd6);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4'd7);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(4'd8);
    localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(4'd9);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic [2:0]         br_type;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] write_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } id_ex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_mem_t;

    logic [5:0] op_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic [5:0] funct_s;
    logic       unused_shamt_s;

    ex_ctrl_t  ex_dec_s;
    mem_ctrl_t mem_dec_s;
    wb_ctrl_t  wb_dec_s;
    logic      jump_s;
    logic      jr_s;
    logic      jal_s;
    logic      legal_s;
    logic      reads_rt_s;

    id_ex_t  id_bundle_s;
    id_ex_t  id_ex_next_s;
    logic    kill_s;
    logic    hazard_s;
    logic    stall_s;

    id_ex_t   id_ex_r;
    ex_mem_t  ex_mem_r;
    wb_ctrl_t mem_wb_r;

    assign op_s           = bus.Instruction[31:26];
    assign rs_s           = bus.Instruction[25:21];
    assign rt_s           = bus.Instruction[20:16];
    assign rd_s           = bus.Instruction[15:11];
    assign funct_s        = bus.Instruction[5:0];
    assign unused_shamt_s = ^bus.Instruction[10:6];

    // Instruction decode into raw per-stage control fields.
    always_comb begin
        ex_dec_s   = '0;
        mem_dec_s  = '0;
        wb_dec_s   = '0;
        jump_s     = 1'b0;
        jr_s       = 1'b0;
        jal_s      = 1'b0;
        legal_s    = 1'b1;
        reads_rt_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                reads_rt_s         = 1'b1;
                wb_dec_s.reg_write = 1'b1;
                wb_dec_s.write_reg = REG_W'(rd_s);
                case (funct_s)
                    F_ADD: ex_dec_s.alu_op = ALU_ADD;
                    F_SUB: ex_dec_s.alu_op = ALU_SUB;
                    F_AND: ex_dec_s.alu_op = ALU_AND;
                    F_OR:  ex_dec_s.alu_op = ALU_OR;
                    F_XOR: ex_dec_s.alu_op = ALU_XOR;
                    F_NOR: ex_dec_s.alu_op = ALU_NOR;
                    F_SLT: ex_dec_s.alu_op = ALU_SLT;
                    F_SLL: ex_dec_s.alu_op = ALU_SLL;
                    F_SRL: ex_dec_s.alu_op = ALU_SRL;
                    F_MUL: ex_dec_s.alu_op = ALU_MUL;
                    F_JR: begin
                        jr_s               = 1'b1;
                        wb_dec_s.reg_write = 1'b0;
                        wb_dec_s.write_reg = '0;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                ex_dec_s.alu_src   = 1'b1;
                wb_dec_s.reg_write = 1'b1;
                wb_dec_s.write_reg = REG_W'(rt_s);
                case (op_s)
                    OP_SLTI: ex_dec_s.alu_op = ALU_SLT;
                    OP_ANDI: ex_dec_s.alu_op = ALU_AND;
                    OP_ORI:  ex_dec_s.alu_op = ALU_OR;
                    OP_XORI: ex_dec_s.alu_op = ALU_XOR;
                    default: ex_dec_s.alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                ex_dec_s.alu_src    = 1'b1;
                mem_dec_s.mem_read  = 1'b1;
                wb_dec_s.reg_write  = 1'b1;
                wb_dec_s.mem_to_reg = 1'b1;
                wb_dec_s.write_reg  = REG_W'(rt_s);
                case (op_s)
                    OP_LH:   mem_dec_s.mem_size = 2'd1;
                    OP_LB:   mem_dec_s.mem_size = 2'd2;
                    default: mem_dec_s.mem_size = 2'd0;
                endcase
            end
            OP_SW, OP_SH, OP_SB: begin
                reads_rt_s          = 1'b1;
                ex_dec_s.alu_src    = 1'b1;
                mem_dec_s.mem_write = 1'b1;
                case (op_s)
                    OP_SH:   mem_dec_s.mem_size = 2'd1;
                    OP_SB:   mem_dec_s.mem_size = 2'd2;
                    default: mem_dec_s.mem_size = 2'd0;
                endcase
            end
            OP_BEQ: begin
                reads_rt_s       = 1'b1;
                ex_dec_s.alu_op  = ALU_SUB;
                ex_dec_s.br_type = 3'd1;
            end
            OP_BNE: begin
                reads_rt_s       = 1'b1;
                ex_dec_s.alu_op  = ALU_SUB;
                ex_dec_s.br_type = 3'd2;
            end
            OP_REGIMM: begin
                ex_dec_s.alu_op = ALU_SUB;
                case (rt_s)
                    5'd0:    ex_dec_s.br_type = 3'd3;
                    5'd1:    ex_dec_s.br_type = 3'd4;
                    default: legal_s = 1'b0;
                endcase
            end
            OP_J: begin
                jump_s = 1'b1;
            end
            OP_JAL: begin
                jump_s             = 1'b1;
                jal_s              = 1'b1;
                wb_dec_s.reg_write = 1'b1;
                wb_dec_s.write_reg = REG_W'(5'd31);
            end
            default: legal_s = 1'b0;
        endcase
        // $0 is hard-wired, so a write to it is dropped
        wb_dec_s.reg_write = wb_dec_s.reg_write & (wb_dec_s.write_reg != '0);
    end

    assign id_bundle_s = legal_s ? id_ex_t'{ex: ex_dec_s, mem: mem_dec_s, wb: wb_dec_s} : id_ex_t'('0);

    // Reset, Flush and an empty ID slot all suppress the ID instruction this cycle.
    assign kill_s   = Reset | bus.Flush | ~bus.InstrValid;
    assign hazard_s = HAZARD_EN && id_ex_r.mem.mem_read && (id_ex_r.wb.write_reg != '0) &&
                      ((id_ex_r.wb.write_reg == REG_W'(rs_s)) ||
                       (reads_rt_s && (id_ex_r.wb.write_reg == REG_W'(rt_s))));
    assign stall_s  = hazard_s & ~kill_s;

    assign id_ex_next_s = (kill_s | stall_s) ? id_ex_t'('0) : id_bundle_s;

    // Pipeline registers; reset clears every stage to a bubble at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            id_ex_r  <= '0;
            ex_mem_r <= '0;
            mem_wb_r <= '0;
        end else begin
            id_ex_r      <= id_ex_next_s;
            ex_mem_r.mem <= id_ex_r.mem;
            ex_mem_r.wb  <= id_ex_r.wb;
            mem_wb_r     <= ex_mem_r.wb;
        end
    end

    assign bus.Stall        = stall_s;
    assign bus.Jump         = jump_s  & legal_s & ~kill_s;
    assign bus.JRMux        = jr_s    & legal_s & ~kill_s;
    assign bus.JalMux       = jal_s   & legal_s & ~kill_s;
    assign bus.IllegalInstr = ~legal_s & ~kill_s;

    assign bus.EX_ALUOp     = id_ex_r.ex.alu_op;
    assign bus.EX_ALUSrc    = id_ex_r.ex.alu_src;
    assign bus.EX_BrType    = id_ex_r.ex.br_type;
    assign bus.MEM_MemRead  = ex_mem_r.mem.mem_read;
    assign bus.MEM_MemWrite = ex_mem_r.mem.mem_write;
    assign bus.MEM_Size     = ex_mem_r.mem.mem_size;
    assign bus.WB_RegWrite  = mem_wb_r.reg_write;
    assign bus.WB_MemToReg  = mem_wb_r.mem_to_reg;
    assign bus.WB_WriteReg  = mem_wb_r.write_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed-vector bench for pipelined_control_unit with hand-computed expectations.
module tb_pipelined_control_unit;

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_ADD3     = 32'h0022_1820;
    localparam logic [31:0] I_LW5      = 32'h8C25_0000;
    localparam logic [31:0] I_ADD6     = 32'h00A2_3020;
    localparam logic [31:0] I_LB5      = 32'h8025_0000;
    localparam logic [31:0] I_ORI6     = 32'h34E6_0001;
    localparam logic [31:0] I_ADDI5    = 32'h20E5_0001;
    localparam logic [31:0] I_JAL      = 32'h0C00_0000;
    localparam logic [31:0] I_JR       = 32'h03E0_0008;
    localparam logic [31:0] I_ILLEGAL  = 32'hFC00_0000;
    localparam logic [31:0] I_ADDI0    = 32'h2020_0005;
    localparam logic [31:0] I_BGEZ     = 32'h0401_0000;
    localparam logic [31:0] I_BLTZ     = 32'h0400_0000;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_pass;

    pipelined_control_unit_if #(.ALUOP_W(4), .REG_W(5)) bus ();

    pipelined_control_unit #(.ALUOP_W(4), .REG_W(5), .HAZARD_EN(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr);
        bus.Instruction = instr;
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        Reset           = 1'b1;
        bus.Instruction = I_NOP;
        bus.InstrValid  = 1'b0;
        bus.Flush       = 1'b0;

        // reset state
        tick();
        check("rst_ex_aluop",  32'(bus.EX_ALUOp), 32'd0);
        check("rst_mem_read",  32'(bus.MEM_MemRead), 32'd0);
        check("rst_wb_write",  32'(bus.WB_RegWrite), 32'd0);
        check("rst_stall",     32'(bus.Stall), 32'd0);
        Reset          = 1'b0;
        bus.InstrValid = 1'b1;

        // add $3,$1,$2 through the pipe
        present(I_ADD3);
        tick();
        check("add_ex_aluop",  32'(bus.EX_ALUOp), 32'd0);
        check("add_ex_alusrc", 32'(bus.EX_ALUSrc), 32'd0);
        present(I_NOP);
        tick();
        check("nop_ex_aluop",  32'(bus.EX_ALUOp), 32'd7);
        tick();
        check("add_wb_write",  32'(bus.WB_RegWrite), 32'd1);
        check("add_wb_reg",    32'(bus.WB_WriteReg), 32'd3);
        check("add_wb_m2r",    32'(bus.WB_MemToReg), 32'd0);

        // lw $5 then dependent add $6,$5,$2
        present(I_LW5);
        tick();
        check("lw_ex_alusrc",  32'(bus.EX_ALUSrc), 32'd1);
        present(I_ADD6);
        check("lu_stall_on",   32'(bus.Stall), 32'd1);
        tick();
        check("lu_ex_bubble",  32'(bus.EX_ALUSrc), 32'd0);
        check("lu_mem_read",   32'(bus.MEM_MemRead), 32'd1);
        check("lu_stall_off",  32'(bus.Stall), 32'd0);
        tick();
        check("lu_mem_bubble", 32'(bus.MEM_MemRead), 32'd0);
        check("lw_wb_reg",     32'(bus.WB_WriteReg), 32'd5);
        check("lw_wb_m2r",     32'(bus.WB_MemToReg), 32'd1);
        check("add6_ex_aluop", 32'(bus.EX_ALUOp), 32'd0);
        present(I_NOP);
        tick();
        tick();
        check("add6_wb_reg",   32'(bus.WB_WriteReg), 32'd6);
        check("add6_wb_write", 32'(bus.WB_RegWrite), 32'd1);

        // lb $5 then independent ori $6,$7,1
        present(I_LB5);
        tick();
        present(I_ORI6);
        check("lb_ori_stall",  32'(bus.Stall), 32'd0);
        tick();
        check("ori_ex_aluop",  32'(bus.EX_ALUOp), 32'd3);
        check("ori_ex_alusrc", 32'(bus.EX_ALUSrc), 32'd1);
        check("lb_mem_size",   32'(bus.MEM_Size), 32'd2);
        check("lb_mem_read",   32'(bus.MEM_MemRead), 32'd1);

        // addi writes rt but does not read it: no stall on rt match
        present(I_LW5);
        tick();
        present(I_ADDI5);
        check("addi_rt_stall", 32'(bus.Stall), 32'd0);
        tick();

        // Flush overrides a load-use stall
        present(I_LW5);
        tick();
        bus.Flush = 1'b1;
        present(I_ADD6);
        check("flush_stall",   32'(bus.Stall), 32'd0);
        tick();
        bus.Flush = 1'b0;

        // jal, then the same jal flushed
        present(I_JAL);
        check("jal_jump",      32'(bus.Jump), 32'd1);
        check("jal_jalmux",    32'(bus.JalMux), 32'd1);
        check("jal_jrmux",     32'(bus.JRMux), 32'd0);
        tick();
        present(I_NOP);
        tick();
        tick();
        check("jal_wb_reg",    32'(bus.WB_WriteReg), 32'd31);
        check("jal_wb_write",  32'(bus.WB_RegWrite), 32'd1);
        bus.Flush = 1'b1;
        present(I_JAL);
        check("fjal_jump",     32'(bus.Jump), 32'd0);
        check("fjal_jalmux",   32'(bus.JalMux), 32'd0);
        tick();
        bus.Flush = 1'b0;
        present(I_NOP);
        tick();
        tick();
        check("fjal_wb_write", 32'(bus.WB_RegWrite), 32'd0);
        check("fjal_wb_reg",   32'(bus.WB_WriteReg), 32'd0);

        // InstrValid=0 suppresses ID outputs; jr decode
        bus.InstrValid = 1'b0;
        present(I_JAL);
        check("inval_jump",    32'(bus.Jump), 32'd0);
        bus.InstrValid = 1'b1;
        present(I_JR);
        check("jr_jrmux",      32'(bus.JRMux), 32'd1);
        check("jr_jump",       32'(bus.Jump), 32'd0);

        // illegal opcode becomes a bubble
        present(I_ILLEGAL);
        check("ill_flag",      32'(bus.IllegalInstr), 32'd1);
        tick();
        check("ill_ex_bubble", 32'(bus.EX_ALUOp), 32'd0);

        // addi $0 never writes
        present(I_ADDI0);
        check("addi0_ill",     32'(bus.IllegalInstr), 32'd0);
        tick();
        check("addi0_alusrc",  32'(bus.EX_ALUSrc), 32'd1);
        present(I_NOP);
        tick();
        tick();
        check("addi0_wb_wr",   32'(bus.WB_RegWrite), 32'd0);

        // REGIMM branches
        present(I_BGEZ);
        tick();
        check("bgez_brtype",   32'(bus.EX_BrType), 32'd4);
        present(I_BLTZ);
        tick();
        check("bltz_brtype",   32'(bus.EX_BrType), 32'd3);
        check("bltz_aluop",    32'(bus.EX_ALUOp), 32'd1);

        // asynchronous reset mid-stream with lw in MEM
        present(I_LW5);
        tick();
        present(I_NOP);
        tick();
        check("pre_rst_mread", 32'(bus.MEM_MemRead), 32'd1);
        check("pre_rst_exop",  32'(bus.EX_ALUOp), 32'd7);
        #2 Reset = 1'b1;
        #1;
        check("arst_mem_read", 32'(bus.MEM_MemRead), 32'd0);
        check("arst_ex_aluop", 32'(bus.EX_ALUOp), 32'd0);
        present(I_JAL);
        check("arst_jump",     32'(bus.Jump), 32'd0);
        tick();
        check("arst_hold_ex",  32'(bus.EX_ALUOp), 32'd0);
        check("arst_hold_wb",  32'(bus.WB_RegWrite), 32'd0);
        Reset = 1'b0;
        present(I_ORI6);
        tick();
        check("post_rst_ori",  32'(bus.EX_ALUOp), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation MIPS control unit for the five-stage datapath. It decodes the 32-bit instruction held in ID and carries the control bundle through internal ID/EX, EX/MEM and MEM/WB registers, so each stage's outputs are already aligned to that stage. It detects load-use hazards and produces Stall. It accepts a branch/jump Flush and inserts bubbles. It flags illegal opcodes.

Parameters:
ALUOP_W, 4, width of ALU operation code (min 4)
REG_W, 5, register-address width
HAZARD_EN, 1, 1 = load-use detection active; 0 = Stall tied 0

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
Instruction  in  32  instruction currently in ID (from IF/ID register)
InstrValid  in  1  0 = treat ID as bubble
Flush  in  1  kill instruction in ID (taken branch/jump)
Stall  out  1  hold PC and IF/ID; combinational from ID + EX state
Jump  out  1  ID: j/jal
JRMux  out  1  ID: jr
JalMux  out  1  ID: jal
IllegalInstr  out  1  ID: valid, unrecognised encoding
EX_ALUOp  out  ALUOP_W  EX: ALU op
EX_ALUSrc  out  1  EX: 1 = immediate operand
EX_BrType  out  3  EX: 0 none, 1 beq, 2 bne, 3 bltz, 4 bgez
MEM_MemRead  out  1  MEM: load
MEM_MemWrite  out  1  MEM: store
MEM_Size  out  2  MEM: 0 word, 1 half, 2 byte
WB_RegWrite  out  1  WB: write register file
WB_MemToReg  out  1  WB: 1 = memory data
WB_WriteReg  out  REG_W  WB: destination register

Behaviour:
- Decode (comb.): op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- ALUOp codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, MUL 9.
- R-type (op 0), by funct:
  - 20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 00 sll, 02 srl, 18 mul.
  - All write rd.
  - funct 08 is jr: JRMux=1, no write.
- I-type: op 08 addi, 0C andi, 0D ori, 0E xori, 0A slti. ALUSrc=1, write rt.
- Loads, write rt, ALU ADD: op 23 lw, 21 lh, 20 lb.
- Stores, ALU ADD, no write: op 2B sw, 29 sh, 28 sb.
- Branches, ALU SUB, no write: op 04 beq, 05 bne; op 01 with rt 0 bltz, rt 1 bgez.
- Jumps: op 02 j. op 03 jal: Jump=JalMux=1, RegWrite=1, WriteReg=31.
- Destination 0 forces RegWrite=0.
- Any other encoding: IllegalInstr=1, decoded as bubble.
- Bubble = all control zero, BrType 0, WriteReg 0.
- Pipeline: every Clk edge, ID/EX <- decoded bundle (or bubble), EX/MEM <- ID/EX, MEM/WB <- EX/MEM. No back-pressure downstream.
- Latency from ID to outputs: EX outputs 1 cycle after decode; MEM outputs 2 cycles; WB outputs 3 cycles.
- Load-use hazard (HAZARD_EN=1):
  - Condition: ID/EX is a load, its dest != 0, and dest == rs of ID instr, or dest == rt when the ID instr reads rt.
  - Instrs reading rt: R-type, stores, beq, bne.
  - Effect: Stall=1 and ID/EX loads a bubble. The instruction is re-presented next cycle, and Stall then deasserts (single-cycle stall).
- Flush: ID/EX loads a bubble. Jump, JRMux, JalMux, IllegalInstr and Stall forced 0.
- Priority: Reset > Flush > Stall > normal.
- InstrValid=0: same as Flush, but only for the current cycle.
- Reset (async, mid-operation too): all pipeline registers -> bubble immediately, so every output reads 0. The first decode is captured on the first edge after Reset falls.

Test Plan:
- Reset mid-stream, lw in MEM -> MEM_MemRead drops to 0 the same instant, before the next edge. All outputs stay 0 until post-reset decode.
- add $3,$1,$2 (0x00221820) -> EX_ALUOp=0 at +1 cycle; WB_RegWrite=1, WB_WriteReg=3, WB_MemToReg=0 at +3.
- lw $5,0($1) then add $6,$5,$2 -> Stall=1 for exactly one cycle. One bubble appears in EX. The add reaches EX one cycle later with ALUOp 0.
- lb $5 then ori $6,$7,1 (no dependency) -> Stall stays 0. MEM_Size=2 for lb.
- jal (0x0C000000) -> Jump=JalMux=1 in ID; WB_WriteReg=31, WB_RegWrite=1 at +3. Same jal with Flush=1 -> all zero, nothing written.
- op 0x3F -> IllegalInstr=1, bubble in EX. addi $0 -> WB_RegWrite=0. bgez (0x04010000) -> EX_BrType=4.
